// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types, defaults and quadrature decode helpers for the encoder front end
package enc_pkg;

    localparam int ENC_FILT_LEN_DEF = 4;
    localparam int ENC_CNT_W_DEF    = 32;

    typedef logic signed [ENC_CNT_W_DEF-1:0] enc_pos_t;

    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_01 = 2'b01,
        AB_11 = 2'b11,
        AB_10 = 2'b10
    } enc_ab_e;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_UP,
        MOVE_DOWN,
        MOVE_ILLEGAL
    } enc_move_e;

    // Position of an AB state around the Gray cycle 00->01->11->10
    function automatic logic [1:0] ab_phase(input enc_ab_e ab);
        logic [1:0] ph;
        case (ab)
            AB_00:   ph = 2'd0;
            AB_01:   ph = 2'd1;
            AB_11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    function automatic enc_move_e ab_decode(input enc_ab_e prev, input enc_ab_e cur);
        logic [1:0] d;
        enc_move_e  m;
        d = ab_phase(cur) - ab_phase(prev);
        case (d)
            2'd0:    m = MOVE_NONE;
            2'd1:    m = MOVE_UP;
            2'd3:    m = MOVE_DOWN;
            default: m = MOVE_ILLEGAL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/enc_deglitch.sv
// rtl/enc_deglitch.sv - two-flop synchroniser plus stability-count filter for one encoder pin
module enc_deglitch #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic aclr,
    input  logic i_raw,
    output logic o_filt
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign o_filt = r_s2;
        end else begin : g_filt
            localparam int             CW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            localparam logic [CW-1:0]  LAST = CW'(FILT_LEN - 1);

            logic [CW-1:0] r_cnt;
            logic          r_filt;

            // Accept the synced value only after FILT_LEN consecutive differing clocks
            always_ff @(posedge clk) begin
                if (aclr) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_s2 == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_filt <= r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_filt = r_filt;
        end
    endgenerate

endmodule

// File: rtl/enc_quad_decoder.sv
// rtl/enc_quad_decoder.sv - x4 quadrature decoder with index capture; ENC_INDEX_RESET_EN makes index also zero pos
module enc_quad_decoder
    import enc_pkg::*;
#(
    parameter int CNT_W    = ENC_CNT_W_DEF,
    parameter int FILT_LEN = ENC_FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic             dir_inv,
    input  logic             cnt_clr,
    input  logic             idx_ack,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] idx_pos,
    output logic             idx_valid,
    output logic             err,
    output logic             step_pulse,
    output logic             step_dir
);

    logic w_a;
    logic w_b;
    logic w_z;

    enc_deglitch #(.FILT_LEN(FILT_LEN)) u_dg_a (.clk(clk), .aclr(aclr), .i_raw(enc_a), .o_filt(w_a));
    enc_deglitch #(.FILT_LEN(FILT_LEN)) u_dg_b (.clk(clk), .aclr(aclr), .i_raw(enc_b), .o_filt(w_b));
    enc_deglitch #(.FILT_LEN(FILT_LEN)) u_dg_z (.clk(clk), .aclr(aclr), .i_raw(enc_z), .o_filt(w_z));

    logic [1:0]       r_ab_prev;
    logic             r_z_prev;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_idx_pos;
    logic             r_idx_valid;
    logic             r_err;
    logic             r_step_pulse;
    logic             r_step_dir;

    enc_move_e        w_move;
    logic             w_step;
    logic             w_up;
    logic             w_illegal;
    logic             w_z_rise;
    logic             w_idx_clr;
    logic [CNT_W-1:0] w_pos_next;
    logic [CNT_W-1:0] w_pos_cap;

    assign w_move     = ab_decode(enc_ab_e'(r_ab_prev), enc_ab_e'({w_a, w_b}));
    assign w_step     = (w_move == MOVE_UP) || (w_move == MOVE_DOWN);
    assign w_up       = (w_move == MOVE_UP) ^ dir_inv;
    assign w_illegal  = (w_move == MOVE_ILLEGAL);
    assign w_z_rise   = w_z & ~r_z_prev;
    assign w_pos_next = !w_step ? r_pos :
                        w_up    ? r_pos + CNT_W'(1) : r_pos - CNT_W'(1);
    assign w_pos_cap  = cnt_clr ? '0 : w_pos_next;

`ifdef ENC_INDEX_RESET_EN
    assign w_idx_clr = w_z_rise;
`else
    assign w_idx_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_ab_prev    <= 2'b00;
            r_z_prev     <= 1'b0;
            r_pos        <= '0;
            r_idx_pos    <= '0;
            r_idx_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_step_dir   <= 1'b0;
        end else begin
            r_ab_prev    <= {w_a, w_b};
            r_z_prev     <= w_z;
            r_step_pulse <= w_step;
            if (w_step) begin
                r_step_dir <= w_up;
            end

            // cnt_clr wins over any coincident count or index clear
            r_pos <= (cnt_clr || w_idx_clr) ? '0 : w_pos_next;

            if (w_z_rise) begin
                r_idx_pos   <= w_pos_cap;
                r_idx_valid <= 1'b1;
            end else if (idx_ack) begin
                r_idx_valid <= 1'b0;
            end

            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign pos        = r_pos;
    assign idx_pos    = r_idx_pos;
    assign idx_valid  = r_idx_valid;
    assign err        = r_err;
    assign step_pulse = r_step_pulse;
    assign step_dir   = r_step_dir;

endmodule
